// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream program loader into imem
// Packs HDR/LEN/data/CSUM frames into 32-bit words and releases the CPU after a clean load.
module imem_loader #(
   parameter int          ADDR_W = 8,
   parameter int          DEPTH  = 256,
   parameter logic [7:0]  HDR    = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_err,
   output logic [15:0]       words_loaded
);

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR
   } state_t;

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_t      state;
   logic [7:0]  len_hi;
   logic [15:0] n_words;
   logic [7:0]  xor_acc;
   logic [23:0] word_reg;
   logic [1:0]  byte_idx;
   logic [15:0] word_idx;
   logic        accept;
   logic [31:0] word_next;
   logic [16:0] n_next;

   assign accept    = in_valid & in_ready;
   assign word_next = {word_reg, in_data};
   assign n_next    = {1'b0, len_hi, in_data};

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         len_hi       <= 8'h00;
         n_words      <= 16'h0000;
         xor_acc      <= 8'h00;
         word_reg     <= 24'h000000;
         byte_idx     <= 2'd0;
         word_idx     <= 16'h0000;
         in_ready     <= 1'b0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= 32'h0000_0000;
         cpu_reset    <= 1'b1;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
         words_loaded <= 16'h0000;
      end else begin
         in_ready <= 1'b1;
         imem_we  <= 1'b0;
         if (accept) begin
            case (state)
               IDLE: begin
                  if (in_data == HDR) begin
                     state        <= LEN_HI;
                     words_loaded <= 16'h0000;
                  end
               end
               LEN_HI: begin
                  len_hi  <= in_data;
                  xor_acc <= in_data;
                  state   <= LEN_LO;
               end
               LEN_LO: begin
                  n_words  <= n_next[15:0];
                  xor_acc  <= xor_acc ^ in_data;
                  word_idx <= 16'h0000;
                  byte_idx <= 2'd0;
                  if (n_next > DEPTH_L) begin
                     state     <= ERR;
                     load_err  <= 1'b1;
                     load_done <= 1'b0;
                     cpu_reset <= 1'b1;
                  end else if (n_next == 17'd0) begin
                     state <= CSUM;
                  end else begin
                     state <= DATA;
                  end
               end
               DATA: begin
                  xor_acc  <= xor_acc ^ in_data;
                  word_reg <= word_next[23:0];
                  byte_idx <= byte_idx + 2'd1;
                  // The write is registered so it lands exactly one cycle after the 4th byte
                  if (byte_idx == 2'd3) begin
                     imem_we      <= 1'b1;
                     imem_addr    <= word_idx[ADDR_W-1:0];
                     imem_wdata   <= word_next;
                     words_loaded <= words_loaded + 16'd1;
                     word_idx     <= word_idx + 16'd1;
                     if (word_idx == n_words - 16'd1) begin
                        state <= CSUM;
                     end
                  end
               end
               CSUM: begin
                  if (in_data == xor_acc) begin
                     state     <= DONE;
                     load_done <= 1'b1;
                     load_err  <= 1'b0;
                     cpu_reset <= 1'b0;
                  end else begin
                     state     <= ERR;
                     load_err  <= 1'b1;
                     load_done <= 1'b0;
                     cpu_reset <= 1'b1;
                  end
               end
               DONE, ERR: begin
                  if (in_data == HDR) begin
                     state        <= LEN_HI;
                     cpu_reset    <= 1'b1;
                     load_done    <= 1'b0;
                     load_err     <= 1'b0;
                     words_loaded <= 16'h0000;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

   logic        clk;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic        load_done;
   logic        load_err;
   logic [15:0] words_loaded;

   int tests;
   int fails;

   logic [7:0]  wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   imem_loader #(.ADDR_W(8), .DEPTH(256), .HDR(8'hA5)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
      .load_err(load_err), .words_loaded(words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_writes();
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic send_prog_frame(input logic [7:0] csum);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
      send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h18);
      send_byte(8'h20); send_byte(8'h02); send_byte(8'h00); send_byte(8'h24);
      send_byte(8'h00); send_byte(8'h22); send_byte(8'h18); send_byte(8'h20);
      send_byte(csum);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_cycles(2);
      tests++;
      if ({in_ready, cpu_reset, imem_we, load_done, load_err} !== 5'b01000) begin
         fails++;
         $display("FAIL reset_ctrl: got rdy/cpu/we/done/err=%b required 01000",
                  {in_ready, cpu_reset, imem_we, load_done, load_err});
      end
      tests++;
      if ({imem_addr, imem_wdata, words_loaded} !== 56'h0) begin
         fails++;
         $display("FAIL reset_data: got addr=%h wdata=%h words=%0d required 0",
                  imem_addr, imem_wdata, words_loaded);
      end
      reset = 1'b0;
      idle_cycles(1);
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL ready_after_reset: got %b required 1", in_ready);
      end
   endtask

   task automatic test_frame_ok();
      clear_writes();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
      send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h18);
      tests++;
      if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h20010018) begin
         fails++;
         $display("FAIL write_latency: got we=%b addr=%h data=%h required 1/00/20010018",
                  imem_we, imem_addr, imem_wdata);
      end
      send_byte(8'h20); send_byte(8'h02); send_byte(8'h00); send_byte(8'h24);
      send_byte(8'h00); send_byte(8'h22); send_byte(8'h18); send_byte(8'h20);
      send_byte(8'h26);
      idle_cycles(2);
      tests++;
      if (wr_addr_q.size() !== 3) begin
         fails++;
         $display("FAIL ok_write_count: got %0d required 3", wr_addr_q.size());
      end else begin
         tests++;
         if (wr_addr_q[0] !== 8'd0 || wr_addr_q[1] !== 8'd1 || wr_addr_q[2] !== 8'd2) begin
            fails++;
            $display("FAIL ok_addrs: got %h %h %h required 00 01 02",
                     wr_addr_q[0], wr_addr_q[1], wr_addr_q[2]);
         end
         tests++;
         if (wr_data_q[0] !== 32'h20010018 || wr_data_q[1] !== 32'h20020024 ||
             wr_data_q[2] !== 32'h00221820) begin
            fails++;
            $display("FAIL ok_data: got %h %h %h required 20010018 20020024 00221820",
                     wr_data_q[0], wr_data_q[1], wr_data_q[2]);
         end
      end
      tests++;
      if (words_loaded !== 16'd3 || load_done !== 1'b1 || cpu_reset !== 1'b0 ||
          load_err !== 1'b0) begin
         fails++;
         $display("FAIL ok_status: got words=%0d done=%b cpu=%b err=%b required 3/1/0/0",
                  words_loaded, load_done, cpu_reset, load_err);
      end
   endtask

   task automatic test_bad_csum();
      clear_writes();
      send_prog_frame(8'h27);
      idle_cycles(2);
      tests++;
      if (load_err !== 1'b1 || cpu_reset !== 1'b1 || load_done !== 1'b0) begin
         fails++;
         $display("FAIL bad_csum_status: got err=%b cpu=%b done=%b required 1/1/0",
                  load_err, cpu_reset, load_done);
      end
      tests++;
      if (wr_addr_q.size() !== 3 || words_loaded !== 16'd3) begin
         fails++;
         $display("FAIL bad_csum_writes: got %0d pulses words=%0d required 3/3",
                  wr_addr_q.size(), words_loaded);
      end
   endtask

   task automatic test_len_too_big();
      clear_writes();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
      tests++;
      if (load_err !== 1'b1 || cpu_reset !== 1'b1 || load_done !== 1'b0) begin
         fails++;
         $display("FAIL len_big_status: got err=%b cpu=%b done=%b required 1/1/0",
                  load_err, cpu_reset, load_done);
      end
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      idle_cycles(2);
      tests++;
      if (wr_addr_q.size() !== 0 || words_loaded !== 16'd0) begin
         fails++;
         $display("FAIL len_big_writes: got %0d pulses words=%0d required 0/0",
                  wr_addr_q.size(), words_loaded);
      end
   endtask

   task automatic test_junk_empty();
      reset = 1'b1;
      idle_cycles(1);
      reset = 1'b0;
      idle_cycles(1);
      clear_writes();
      send_byte(8'h00); idle_cycles(1); send_byte(8'hFF);
      send_byte(8'hA5); idle_cycles(1); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h00);
      idle_cycles(1);
      tests++;
      if (load_done !== 1'b1 || cpu_reset !== 1'b0 || words_loaded !== 16'd0 ||
          wr_addr_q.size() !== 0) begin
         fails++;
         $display("FAIL junk_empty: got done=%b cpu=%b words=%0d pulses=%0d required 1/0/0/0",
                  load_done, cpu_reset, words_loaded, wr_addr_q.size());
      end
   endtask

   task automatic test_hdr_in_data();
      clear_writes();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hA5); send_byte(8'hA5); send_byte(8'hA5); send_byte(8'hA5);
      send_byte(8'h01);
      idle_cycles(1);
      tests++;
      if (wr_data_q.size() !== 1 || load_done !== 1'b1 || words_loaded !== 16'd1) begin
         fails++;
         $display("FAIL hdr_in_data: got pulses=%0d done=%b words=%0d required 1/1/1",
                  wr_data_q.size(), load_done, words_loaded);
      end else begin
         tests++;
         if (wr_data_q[0] !== 32'hA5A5A5A5 || wr_addr_q[0] !== 8'd0) begin
            fails++;
            $display("FAIL hdr_in_data_word: got %h@%h required a5a5a5a5@00",
                     wr_data_q[0], wr_addr_q[0]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      clear_writes();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55); send_byte(8'h66);
      reset = 1'b1;
      idle_cycles(2);
      tests++;
      if (cpu_reset !== 1'b1 || load_done !== 1'b0 || words_loaded !== 16'd0 ||
          in_ready !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset_status: got cpu=%b done=%b words=%0d rdy=%b required 1/0/0/0",
                  cpu_reset, load_done, words_loaded, in_ready);
      end
      reset = 1'b0;
      idle_cycles(2);
      tests++;
      if (wr_data_q.size() !== 1) begin
         fails++;
         $display("FAIL mid_reset_count: got %0d pulses required 1", wr_data_q.size());
      end else begin
         tests++;
         if (wr_data_q[0] !== 32'h11223344 || wr_addr_q[0] !== 8'd0) begin
            fails++;
            $display("FAIL mid_reset_word: got %h@%h required 11223344@00",
                     wr_data_q[0], wr_addr_q[0]);
         end
      end
      // Bytes that would complete the abandoned word must not produce a write from IDLE
      send_byte(8'h77); send_byte(8'h88);
      clear_writes();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      send_byte(8'h01);
      idle_cycles(1);
      tests++;
      if (load_done !== 1'b1 || cpu_reset !== 1'b0 || wr_data_q.size() !== 1) begin
         fails++;
         $display("FAIL reload_status: got done=%b cpu=%b pulses=%0d required 1/0/1",
                  load_done, cpu_reset, wr_data_q.size());
      end else begin
         tests++;
         if (wr_data_q[0] !== 32'hAABBCCDD) begin
            fails++;
            $display("FAIL reload_word: got %h required aabbccdd", wr_data_q[0]);
         end
      end
   endtask

   task automatic test_restart();
      send_byte(8'h3C);
      tests++;
      if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin
         fails++;
         $display("FAIL done_ignores_junk: got done=%b cpu=%b required 1/0",
                  load_done, cpu_reset);
      end
      send_byte(8'hA5);
      tests++;
      if (cpu_reset !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 ||
          words_loaded !== 16'd0) begin
         fails++;
         $display("FAIL restart_edge: got cpu=%b done=%b err=%b words=%0d required 1/0/0/0",
                  cpu_reset, load_done, load_err, words_loaded);
      end
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      tests++;
      if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin
         fails++;
         $display("FAIL restart_done: got done=%b cpu=%b required 1/0", load_done, cpu_reset);
      end
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #1;
      test_reset();
      test_frame_ok();
      test_bad_csum();
      test_len_too_big();
      test_junk_empty();
      test_hdr_in_data();
      test_reset_mid_frame();
      test_restart();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
